gbf_pingpong_reader: RTL and testbench
======================================

# gbf_pingpong_reader

Parametrised read-side controller for one ping-pong global buffer (GBF) pair, actv or wgt, sitting between the GBF BRAM port-b and the PE-array register-file loader. It tracks each bank as full or empty and raises per-bank `need_data`. It streams a tile from the active bank to the RF in bursts of `BURST_LEN` words, re-streams the same tile `cfg_reuse` times, then releases the bank and switches to the other one. Compared with the fixed-size gbf controller, it adds configurable tile length, partial final bursts, multi-pass reuse, graceful stop and overflow detection.

## Interface
- `ADDR_BITWIDTH`, 5: GBF bank address width.
- `DEPTH`, 32: words per bank (≤ 2^ADDR_BITWIDTH).
- `BURST_LEN`, 4: words per RF load; equals the RF depth.
- `REUSE_BITWIDTH`, 4: width of the reuse counter.
- `clk` in 1: clock.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `start` in 1: pulse in IDLE; latches cfg and begins on bank 0.
- `finish` in 1: level; stop after the current tile completes.
- `cfg_words` in ADDR_BITWIDTH+1: valid words per tile, 1..DEPTH; 0 is treated as 1, >DEPTH is clamped to DEPTH.
- `cfg_reuse` in REUSE_BITWIDTH: passes per tile; 0 is treated as 1.
- `buf_ready` in 2: per-bank pulse from the writer meaning "bank b filled".
- `rf_need_data` in 1: RF requests one burst.
- `need_data` out 2: bank b is empty.
- `en_b` out 1: BRAM port-b read enable.
- `addr_b` out ADDR_BITWIDTH: BRAM port-b address.
- `bank_sel` out 1: bank addressed by `en_b`/`addr_b`.
- `rd_valid` out 1: BRAM read data valid, i.e. `en_b` delayed by 1.
- `rd_bank` out 1: `bank_sel` delayed by 1.
- `rd_last` out 1: with `rd_valid`, marks the last word of the burst.
- `burst_done` out 1: pulse, last read of a burst issued.
- `tile_done` out 1: pulse, bank released.
- `busy` out 1: state ≠ IDLE.
- `ovf_err` out 1: sticky; `buf_ready` arrived for a full bank.

## Operation
- Bank flags: `buf_ready[b]` sets FULL. Release sets EMPTY. `need_data[b]` = !FULL[b].
- FSM states: IDLE, WAIT_BUF, WAIT_REQ, BURST.
  - IDLE: on `start`, latch cfg, set cur=0, pass=0, addr=0, go to WAIT_BUF.
  - WAIT_BUF: if FULL[cur], go to WAIT_REQ.
  - WAIT_REQ: if `rf_need_data`, go to BURST with beat=0.
  - BURST: `en_b`=1 and `addr_b`=addr; addr++ and beat++ each cycle. The burst ends when beat==BURST_LEN-1 or addr==words-1, whichever comes first; the final burst is short when `cfg_words` mod BURST_LEN ≠ 0.
- End of burst, not end of tile: go to WAIT_REQ; addr continues.
- End of tile with pass+1 < reuse: pass++, addr=0, go to WAIT_REQ.
- End of tile with pass+1 == reuse: release bank cur, pulse `tile_done`, toggle cur, pass=0, addr=0. Then go to IDLE if `finish` is high, else WAIT_BUF.
- `finish` is sampled only at tile end and never truncates a tile.
- `start` outside IDLE is ignored. Cfg is held stable until the next `start`.
- Same-cycle events:
  - `buf_ready` to the other bank during BURST or a release is accepted normally.
  - `buf_ready` to a bank that is FULL, including the bank being released in that cycle, is ignored and sets `ovf_err`. In the release cycle the bank ends EMPTY.
  - `buf_ready` for both banks in one cycle is handled per bank independently.
- `rf_need_data` outside WAIT_REQ is ignored; the RF re-asserts it as a level.
- Arithmetic: addr wraps only through the explicit reset to 0 and never exceeds words-1. The pass counter is REUSE_BITWIDTH wide.

## Timing
- Reset values: `need_data`=2'b11; all other outputs 0; state IDLE; cur=0; `ovf_err` cleared.
- `reset` mid-burst aborts immediately: both banks EMPTY, no `tile_done`.
- Latency from `rf_need_data` sampled high at edge t:
  - `en_b` high for cycles t+1 .. t+L, where L is the burst length.
  - `rd_valid` high for cycles t+2 .. t+L+1.
  - `rd_last` in cycle t+L+1.
  - `burst_done` in cycle t+L.
- Minimum gap: back-to-back bursts have exactly one WAIT_REQ cycle between them.
- `tile_done` coincides with the last `en_b` cycle of the tile. `need_data[cur]` rises on the next cycle.
- BURST never waits on `rf_need_data`. The RF must accept L words at one per cycle.

## Structure
- Package `gbf_pkg`: the FSM state enum, the bank index type, and the `rd_valid` latency constant (1).
- Sub-module `gbf_bank_flag`: one per bank. Inputs are set (`buf_ready`) and clear (release); outputs are FULL and an overflow pulse. It is instantiated twice, and the top ORs the two overflow pulses into `ovf_err`.

## Test plan
- Single tile, no reuse: cfg_words=8, BURST_LEN=4, reuse=1, `buf_ready[0]`, two requests → addr 0-3 then 4-7 on bank 0. `tile_done` fires on the addr=7 cycle, then `need_data`=2'b11.
- Partial burst plus reuse: cfg_words=6, reuse=3 → each pass is bursts of 4 and 2 with `rd_last` on addr 3 and addr 5. Three passes, then `tile_done` exactly once.
- Ping-pong: both banks ready, `finish`=0 → bank 0 tile, then bank 1 starts with no extra WAIT_BUF cycle. `bank_sel`/`rd_bank` flip after `tile_done`.
- Starvation: bank 1 not ready at the bank-0 release → FSM holds in WAIT_BUF with `en_b`=0. A later `buf_ready[1]` lets it proceed on the following request.
- Overflow and simultaneity: `buf_ready[0]` while bank 0 is FULL → `ovf_err`=1, sticky. `buf_ready[0]` in the release cycle → bank 0 stays EMPTY, `ovf_err`=1.
- Reset mid-burst: `reset` at addr=2 → next cycle `en_b`=0, `need_data`=2'b11, `busy`=0. A subsequent `start` begins again at bank 0, addr 0.

Source files
------------

// File: rtl/gbf_pkg.sv
`default_nettype none
// gbf_pkg -- shared types and constants for the ping-pong GBF reader.
// Rev 1.0
package gbf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BUF = 2'd1,
    ST_WAIT_REQ = 2'd2,
    ST_BURST    = 2'd3
  } state_e;

  typedef logic bank_t;

  localparam int unsigned RD_VALID_LAT = 1;

endpackage
`default_nettype wire

// File: rtl/gbf_bank_flag.sv
`default_nettype none
// gbf_bank_flag -- FULL/EMPTY flag for one GBF bank with overflow pulse.
// Rev 1.0
module gbf_bank_flag (
  input  logic clk_i,
  input  logic reset_i,
  input  logic set_i,
  input  logic clr_i,
  output logic full_o,
  output logic ovf_o
);

  logic full_q;

  // Release wins over a same-cycle fill: the bank always ends EMPTY.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      full_q <= 1'b0;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end else if (set_i) begin
      full_q <= 1'b1;
    end
  end

  assign full_o = full_q;
  assign ovf_o  = set_i & full_q;

endmodule
`default_nettype wire

// File: rtl/gbf_pingpong_reader.sv
`default_nettype none
// gbf_pingpong_reader -- streams tiles from a ping-pong GBF pair into the RF loader.
// Rev 1.0
module gbf_pingpong_reader
  import gbf_pkg::*;
#(
  parameter int ADDR_BITWIDTH  = 5,
  parameter int DEPTH          = 32,
  parameter int BURST_LEN      = 4,
  parameter int REUSE_BITWIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic                      finish_i,
  input  logic [ADDR_BITWIDTH:0]    cfg_words_i,
  input  logic [REUSE_BITWIDTH-1:0] cfg_reuse_i,
  input  logic [1:0]                buf_ready_i,
  input  logic                      rf_need_data_i,
  output logic [1:0]                need_data_o,
  output logic                      en_b_o,
  output logic [ADDR_BITWIDTH-1:0]  addr_b_o,
  output logic                      bank_sel_o,
  output logic                      rd_valid_o,
  output logic                      rd_bank_o,
  output logic                      rd_last_o,
  output logic                      burst_done_o,
  output logic                      tile_done_o,
  output logic                      busy_o,
  output logic                      ovf_err_o
);

  localparam int C_BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int C_WW     = ADDR_BITWIDTH + 1;
  localparam logic [C_WW-1:0]     C_DEPTH     = C_WW'(DEPTH);
  localparam logic [C_BEAT_W-1:0] C_BEAT_LAST = C_BEAT_W'(BURST_LEN - 1);

  state_e                    state_q;
  bank_t                     cur_q;
  logic [REUSE_BITWIDTH-1:0] pass_q;
  logic [REUSE_BITWIDTH-1:0] reuse_q;
  logic [ADDR_BITWIDTH-1:0]  addr_q;
  logic [C_BEAT_W-1:0]       beat_q;
  logic [C_WW-1:0]           words_q;
  logic                      rd_valid_q;
  logic                      rd_bank_q;
  logic                      rd_last_q;
  logic                      ovf_q;

  logic [1:0]                w_full;
  logic [1:0]                w_ovf;
  logic [1:0]                w_clr;
  logic [C_WW-1:0]           w_words_cfg;
  logic [REUSE_BITWIDTH-1:0] w_reuse_cfg;
  logic                      w_in_burst;
  logic                      w_last_addr;
  logic                      w_burst_end;
  logic                      w_last_pass;
  logic                      w_release;

  always_comb begin
    w_words_cfg = cfg_words_i;
    if (cfg_words_i == '0) begin
      w_words_cfg = C_WW'(1);
    end else if (cfg_words_i > C_DEPTH) begin
      w_words_cfg = C_DEPTH;
    end
    w_reuse_cfg = (cfg_reuse_i == '0) ? REUSE_BITWIDTH'(1) : cfg_reuse_i;
  end

  assign w_in_burst  = (state_q == ST_BURST);
  assign w_last_addr = ({1'b0, addr_q} == (words_q - C_WW'(1)));
  assign w_burst_end = w_last_addr || (beat_q == C_BEAT_LAST);
  assign w_last_pass = (pass_q == (reuse_q - REUSE_BITWIDTH'(1)));
  assign w_release   = w_in_burst && w_last_addr && w_last_pass;
  assign w_clr       = {w_release && cur_q, w_release && !cur_q};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    gbf_bank_flag u_flag (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .set_i   (buf_ready_i[b]),
      .clr_i   (w_clr[b]),
      .full_o  (w_full[b]),
      .ovf_o   (w_ovf[b])
    );
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cur_q   <= 1'b0;
      pass_q  <= '0;
      addr_q  <= '0;
      beat_q  <= '0;
      words_q <= C_WW'(1);
      reuse_q <= REUSE_BITWIDTH'(1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            words_q <= w_words_cfg;
            reuse_q <= w_reuse_cfg;
            cur_q   <= 1'b0;
            pass_q  <= '0;
            addr_q  <= '0;
            state_q <= ST_WAIT_BUF;
          end
        end
        ST_WAIT_BUF: begin
          if (w_full[cur_q]) begin
            state_q <= ST_WAIT_REQ;
          end
        end
        ST_WAIT_REQ: begin
          if (rf_need_data_i) begin
            beat_q  <= '0;
            state_q <= ST_BURST;
          end
        end
        ST_BURST: begin
          addr_q <= addr_q + ADDR_BITWIDTH'(1);
          beat_q <= beat_q + C_BEAT_W'(1);
          if (w_burst_end) begin
            state_q <= ST_WAIT_REQ;
            if (w_last_addr) begin
              addr_q <= '0;
              if (w_last_pass) begin
                pass_q <= '0;
                cur_q  <= ~cur_q;
                // An already-filled partner bank goes straight to WAIT_REQ.
                if (finish_i) begin
                  state_q <= ST_IDLE;
                end else if (!w_full[~cur_q]) begin
                  state_q <= ST_WAIT_BUF;
                end
              end else begin
                pass_q <= pass_q + REUSE_BITWIDTH'(1);
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_valid_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_last_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rd_valid_q <= w_in_burst;
      rd_bank_q  <= cur_q;
      rd_last_q  <= w_in_burst && w_burst_end;
      ovf_q      <= ovf_q | (|w_ovf);
    end
  end

  assign need_data_o  = ~w_full;
  assign en_b_o       = w_in_burst;
  assign addr_b_o     = addr_q;
  assign bank_sel_o   = cur_q;
  assign rd_valid_o   = rd_valid_q;
  assign rd_bank_o    = rd_bank_q;
  assign rd_last_o    = rd_last_q;
  assign burst_done_o = w_in_burst && w_burst_end;
  assign tile_done_o  = w_release;
  assign busy_o       = (state_q != ST_IDLE);
  assign ovf_err_o    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_gbf_pingpong_reader.sv
`default_nettype none
// tb_gbf_pingpong_reader -- vector table, corner sequences and a randomized stream model.
// Rev 1.0
module tb_gbf_pingpong_reader;

  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int BL    = 4;
  localparam int RW    = 4;

  logic          clk = 1'b0;
  logic          reset, start, finish, rf;
  logic [AW:0]   cfg_words;
  logic [RW-1:0] cfg_reuse;
  logic [1:0]    buf_ready;
  logic [1:0]    need_data;
  logic          en_b, bank_sel, rd_valid, rd_bank, rd_last, burst_done, tile_done, busy, ovf_err;
  logic [AW-1:0] addr_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gbf_pingpong_reader #(
    .ADDR_BITWIDTH (AW),
    .DEPTH         (DEPTH),
    .BURST_LEN     (BL),
    .REUSE_BITWIDTH(RW)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (start),
    .finish_i      (finish),
    .cfg_words_i   (cfg_words),
    .cfg_reuse_i   (cfg_reuse),
    .buf_ready_i   (buf_ready),
    .rf_need_data_i(rf),
    .need_data_o   (need_data),
    .en_b_o        (en_b),
    .addr_b_o      (addr_b),
    .bank_sel_o    (bank_sel),
    .rd_valid_o    (rd_valid),
    .rd_bank_o     (rd_bank),
    .rd_last_o     (rd_last),
    .burst_done_o  (burst_done),
    .tile_done_o   (tile_done),
    .busy_o        (busy),
    .ovf_err_o     (ovf_err)
  );

  typedef struct {
    logic        start;
    logic [1:0]  br;
    logic        rf;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic st, input logic [1:0] br, input logic rq,
                              input logic en, input int ad, input logic sel, input logic rv,
                              input logic rb, input logic rl, input logic bd, input logic td,
                              input logic [1:0] nd, input logic bz);
    vec_t v;
    v.start = st;
    v.br    = br;
    v.rf    = rq;
    v.exp   = {en, 5'(ad), sel, rv, rb, rl, bd, td, nd, bz, 1'b0};
    return v;
  endfunction

  function automatic logic [15:0] outs();
    return {en_b, (en_b ? addr_b : 5'd0), bank_sel, rd_valid, rd_bank, rd_last,
            burst_done, tile_done, need_data, busy, ovf_err};
  endfunction

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; finish = 1'b0; rf = 1'b0; buf_ready = 2'b00;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_for(input string name, input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      sample();
      if ((which == 0 && tile_done) || (which == 1 && en_b) ||
          (which == 2 && en_b && addr_b == 5'd2)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=no_event required=event_within_64_cycles", name);
    end
  endtask

  // Expected read stream: per tile, reuse passes of addresses 0..words-1, banks alternating.
  task automatic run_random(input logic [AW:0] wc, input logic [RW-1:0] rc, input int ncyc);
    int w, r, mp, ma, reads, tiles, starve;
    bit fm[2];
    bit mb, pen, pbd, pbank, prf, ebd, etd;
    logic [1:0] br;
    w = (wc == 0) ? 1 : ((int'(wc) > DEPTH) ? DEPTH : int'(wc));
    r = (rc == 0) ? 1 : int'(rc);
    do_reset();
    cfg_words = wc; cfg_reuse = rc; finish = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    fm = '{1'b0, 1'b0};
    mb = 1'b0; mp = 0; ma = 0; reads = 0; tiles = 0; starve = 0;
    pen = 1'b0; pbd = 1'b0; pbank = 1'b0; prf = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      rf = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < 2; b++) br[b] = !fm[b] && ($urandom_range(0, 7) == 0);
      buf_ready = br;
      sample();
      check("rnd_need", need_data, {~fm[1], ~fm[0]});
      check("rnd_rd", {rd_valid, (rd_valid ? {rd_bank, rd_last} : 2'b00)},
            {pen, (pen ? {pbank, pbd} : 2'b00)});
      if (en_b) begin
        ebd = (ma % BL == BL - 1) || (ma == w - 1);
        etd = (ma == w - 1) && (mp == r - 1);
        check("rnd_read", {fm[mb], bank_sel, addr_b, burst_done, tile_done},
              {1'b1, mb, 5'(ma), ebd, etd});
        if (!pen) check("rnd_req_lat", prf, 1);
        if (pen) check("rnd_gap", pbd, 0);
        pbd = ebd;
        pbank = mb;
        reads++;
        starve = 0;
        if (etd) begin
          fm[mb] = 1'b0; mb = ~mb; mp = 0; ma = 0; tiles++;
        end else if (ma == w - 1) begin
          mp++; ma = 0;
        end else begin
          ma++;
        end
      end else begin
        check("rnd_quiet", {burst_done, tile_done, (pen && !pbd)}, 0);
        if (fm[mb] && rf) starve++;
      end
      check("rnd_live", (starve <= 3), 1);
      for (int b = 0; b < 2; b++) if (br[b]) fm[b] = 1'b1;
      pen = en_b;
      prf = rf;
      step();
    end
    buf_ready = 2'b00;
    rf = 1'b0;
    sample();
    check("rnd_progress", (tiles > 0 && reads >= tiles * w), 1);
    check("rnd_ovf", ovf_err, 0);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    logic [AW:0] rw;
    logic [RW-1:0] rr;
    cfg_words = '0; cfg_reuse = '0;
    do_reset();

    sample();
    check("reset_state", outs(), {1'b0, 5'd0, 6'b0, 2'b11, 2'b00});
    step();

    // Single tile of 8 words, two bursts, finish held high.
    //             st  br    rf  en ad sel rv rb rl bd td need   busy
    tbl[0]  = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0);
    tbl[1]  = mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1);
    tbl[2]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1);
    tbl[3]  = mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1);
    tbl[4]  = mk(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1);
    tbl[5]  = mk(0, 2'b00, 1, 1, 1, 0, 1, 0, 0, 0, 0, 2'b10, 1);
    tbl[6]  = mk(1, 2'b00, 0, 1, 2, 0, 1, 0, 0, 0, 0, 2'b10, 1);
    tbl[7]  = mk(0, 2'b00, 0, 1, 3, 0, 1, 0, 0, 1, 0, 2'b10, 1);
    tbl[8]  = mk(0, 2'b00, 1, 0, 0, 0, 1, 0, 1, 0, 0, 2'b10, 1);
    tbl[9]  = mk(0, 2'b00, 0, 1, 4, 0, 0, 0, 0, 0, 0, 2'b10, 1);
    tbl[10] = mk(0, 2'b00, 0, 1, 5, 0, 1, 0, 0, 0, 0, 2'b10, 1);
    tbl[11] = mk(0, 2'b00, 0, 1, 6, 0, 1, 0, 0, 0, 0, 2'b10, 1);
    tbl[12] = mk(0, 2'b00, 0, 1, 7, 0, 1, 0, 0, 1, 1, 2'b10, 1);
    tbl[13] = mk(0, 2'b00, 0, 0, 0, 1, 1, 0, 1, 0, 0, 2'b11, 0);
    tbl[14] = mk(0, 2'b00, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b11, 0);

    cfg_words = 6'd8; cfg_reuse = 4'd1; finish = 1'b1;
    for (int i = 0; i < 15; i++) begin
      start = tbl[i].start; buf_ready = tbl[i].br; rf = tbl[i].rf;
      sample();
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
      step();
    end
    start = 1'b0; buf_ready = 2'b00; rf = 1'b0;

    // Overflow is sticky.
    do_reset();
    cfg_words = 6'd4; cfg_reuse = 4'd1; start = 1'b1;
    step();
    start = 1'b0; buf_ready = 2'b01;
    step();
    buf_ready = 2'b00;
    sample();
    check("ovf_clear", ovf_err, 0);
    step();
    buf_ready = 2'b01;
    step();
    buf_ready = 2'b00;
    sample();
    check("ovf_set", {ovf_err, need_data}, {1'b1, 2'b10});
    repeat (5) step();
    sample();
    check("ovf_sticky", ovf_err, 1);
    step();

    // Refill of the bank being released: ends EMPTY and flags overflow.
    do_reset();
    cfg_words = 6'd3; cfg_reuse = 4'd2; finish = 1'b1; start = 1'b1;
    step();
    start = 1'b0; buf_ready = 2'b01;
    step();
    buf_ready = 2'b00; rf = 1'b1;
    wait_for("col_tile", 0, ok);
    if (ok) begin
      buf_ready = 2'b01;
      step();
      buf_ready = 2'b00; rf = 1'b0;
      sample();
      check("col_release", {need_data, ovf_err, busy, tile_done}, {2'b11, 1'b1, 1'b0, 1'b0});
    end
    step();

    // Reset mid-burst, then a clean restart on bank 0.
    do_reset();
    cfg_words = 6'd8; cfg_reuse = 4'd1; finish = 1'b0; start = 1'b1;
    step();
    start = 1'b0; buf_ready = 2'b01;
    step();
    buf_ready = 2'b00; rf = 1'b1;
    wait_for("rst_wait", 2, ok);
    if (ok) begin
      reset = 1'b1;
      step();
      reset = 1'b0; rf = 1'b0;
      sample();
      check("rst_mid", {en_b, need_data, busy, tile_done, rd_valid}, {1'b0, 2'b11, 3'b000});
      step();
      start = 1'b1;
      step();
      start = 1'b0; buf_ready = 2'b01;
      step();
      buf_ready = 2'b00; rf = 1'b1;
      wait_for("rst_restart", 1, ok);
      if (ok) check("rst_restart_addr", {bank_sel, addr_b}, {1'b0, 5'd0});
    end
    step();
    rf = 1'b0;

    // Ping-pong with both banks ready, then starvation on the empty bank.
    do_reset();
    cfg_words = 6'd2; cfg_reuse = 4'd1; finish = 1'b0; start = 1'b1;
    step();
    start = 1'b0; buf_ready = 2'b11;
    step();
    buf_ready = 2'b00; rf = 1'b1;
    wait_for("pp_tile0", 0, ok);
    if (ok) begin
      check("pp_tile0_bank", {bank_sel, addr_b}, {1'b0, 5'd1});
      step(); sample();
      check("pp_gap", {en_b, bank_sel, need_data}, {1'b0, 1'b1, 2'b01});
      step(); sample();
      check("pp_bank1", {en_b, bank_sel, addr_b}, {1'b1, 1'b1, 5'd0});
      step(); sample();
      check("pp_bank1_end", {en_b, addr_b, tile_done, rd_valid, rd_bank}, {1'b1, 5'd1, 3'b111});
      step();
      for (int i = 0; i < 8; i++) begin
        sample();
        check("starve_hold", {en_b, busy, need_data}, {1'b0, 1'b1, 2'b11});
        step();
      end
      buf_ready = 2'b01;
      step();
      buf_ready = 2'b00;
      wait_for("starve_resume", 1, ok);
      if (ok) check("starve_bank", {bank_sel, addr_b}, {1'b0, 5'd0});
    end
    step();
    rf = 1'b0;

    // Randomized traffic against the stream model.
    run_random(6'd6, 4'd3, 1500);
    run_random(6'd0, 4'd0, 1000);
    run_random(6'd40, 4'd2, 1500);
    rw = 6'($urandom_range(1, 33));
    rr = 4'($urandom_range(0, 5));
    run_random(rw, rr, 1500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
